// File: rtl/mux2_share_arbiter.sv
// Two valid/ready requesters share one 2:1 mux feeding a single-entry output
// register; round-robin grant with a burst cap keeps either side from starving.
module mux2_share_arbiter #(
    parameter int WIDTH     = 16,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             sel,
    output logic             z_valid,
    output logic [WIDTH-1:0] z_data,
    output logic             z_src,
    input  logic             z_ready
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(BURST_MAX);
    localparam logic SRC_X = 1'b0;
    localparam logic SRC_Y = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_X = 2'd1,
        GRANT_Y = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic [CNT_W-1:0]   burst_cnt_nxt_s;
    logic               last_served_r;
    logic               last_served_nxt_s;
    logic               z_valid_r;
    logic [WIDTH-1:0]   z_data_r;
    logic               z_src_r;

    logic               out_free_s;
    logic               x_ready_s;
    logic               y_ready_s;
    logic               xfer_x_s;
    logic               xfer_y_s;
    logic [CNT_W:0]     cnt_sum_s;
    logic [CNT_W-1:0]   cnt_sat_s;
    logic               at_cap_s;

    // Handshake qualifiers; the output stage is free when empty or draining.
    always_comb begin
        out_free_s = !z_valid_r || z_ready;
        x_ready_s  = (state_r == GRANT_X) && out_free_s;
        y_ready_s  = (state_r == GRANT_Y) && out_free_s;
        xfer_x_s   = x_valid && x_ready_s;
        xfer_y_s   = y_valid && y_ready_s;
    end

    // Saturating burst counter; only the granted side can transfer, so one counter serves both.
    always_comb begin
        cnt_sum_s = {1'b0, burst_cnt_r} + {{CNT_W{1'b0}}, (xfer_x_s | xfer_y_s)};
        if (cnt_sum_s >= BURST_LIM) begin
            cnt_sat_s = BURST_LIM[CNT_W-1:0];
        end else begin
            cnt_sat_s = cnt_sum_s[CNT_W-1:0];
        end
        at_cap_s = (cnt_sat_s == BURST_LIM[CNT_W-1:0]);
    end

    // Grant FSM next-state, burst count and round-robin history.
    always_comb begin
        state_nxt_s       = state_r;
        burst_cnt_nxt_s   = burst_cnt_r;
        last_served_nxt_s = last_served_r;
        case (state_r)
            IDLE: begin
                burst_cnt_nxt_s = {CNT_W{1'b0}};
                if (x_valid && (!y_valid || (last_served_r == SRC_Y))) begin
                    state_nxt_s = GRANT_X;
                end else if (y_valid) begin
                    state_nxt_s = GRANT_Y;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT_X: begin
                if (xfer_x_s) begin
                    last_served_nxt_s = SRC_X;
                end else begin
                    last_served_nxt_s = last_served_r;
                end
                if (!x_valid) begin
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                    if (y_valid) begin
                        state_nxt_s = GRANT_Y;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (at_cap_s && y_valid) begin
                    // X holds its valid and is re-granted later by round-robin.
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                    state_nxt_s     = GRANT_Y;
                end else begin
                    burst_cnt_nxt_s = cnt_sat_s;
                    state_nxt_s     = GRANT_X;
                end
            end
            GRANT_Y: begin
                if (xfer_y_s) begin
                    last_served_nxt_s = SRC_Y;
                end else begin
                    last_served_nxt_s = last_served_r;
                end
                if (!y_valid) begin
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                    if (x_valid) begin
                        state_nxt_s = GRANT_X;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (at_cap_s && x_valid) begin
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                    state_nxt_s     = GRANT_X;
                end else begin
                    burst_cnt_nxt_s = cnt_sat_s;
                    state_nxt_s     = GRANT_Y;
                end
            end
            default: begin
                state_nxt_s       = IDLE;
                burst_cnt_nxt_s   = {CNT_W{1'b0}};
                last_served_nxt_s = SRC_Y;
            end
        endcase
    end

    // Arbiter state registers; reset leaves Y as last served so X wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            burst_cnt_r   <= {CNT_W{1'b0}};
            last_served_r <= SRC_Y;
        end else begin
            state_r       <= state_nxt_s;
            burst_cnt_r   <= burst_cnt_nxt_s;
            last_served_r <= last_served_nxt_s;
        end
    end

    // One-entry output stage: load on accept (overwrites during a drain), clear valid on drain only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_valid_r <= 1'b0;
            z_data_r  <= {WIDTH{1'b0}};
            z_src_r   <= 1'b0;
        end else if (xfer_x_s) begin
            z_valid_r <= 1'b1;
            z_data_r  <= x_data;
            z_src_r   <= SRC_X;
        end else if (xfer_y_s) begin
            z_valid_r <= 1'b1;
            z_data_r  <= y_data;
            z_src_r   <= SRC_Y;
        end else if (z_ready) begin
            z_valid_r <= 1'b0;
        end else begin
            z_valid_r <= z_valid_r;
        end
    end

    assign x_ready = x_ready_s;
    assign y_ready = y_ready_s;
    assign sel     = (state_r == GRANT_Y);
    assign z_valid = z_valid_r;
    assign z_data  = z_data_r;
    assign z_src   = z_src_r;

endmodule

// File: doc/mux2_share_arbiter.md
Name: mux2_share_arbiter

Overview:
- Shares the 16-bit 2:1 mux datapath (X/Y inputs, select S, output Z) between two valid/ready requesters.
- Drives the mux select and registers the mux output into a one-entry output stage with a valid/ready handshake to the consumer.
- Round-robin arbitration with a burst cap so neither requester can starve the other; sits between the operand sources and the downstream ALU stage.

Parameters:
- WIDTH, 16, data width of X/Y/Z.
- BURST_MAX, 4, max consecutive accepted transfers from one requester while the other is waiting (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- x_valid  input  1  requester X has data.
- x_data  input  WIDTH  requester X data (mux input X).
- x_ready  output  1  X transfer accepted this cycle when x_valid && x_ready.
- y_valid  input  1  requester Y has data.
- y_data  input  WIDTH  requester Y data (mux input Y).
- y_ready  output  1  Y transfer accepted this cycle when y_valid && y_ready.
- sel  output  1  mux select S: 0 = X, 1 = Y.
- z_valid  output  1  output register holds data.
- z_data  output  WIDTH  registered mux output Z.
- z_src  output  1  source of z_data: 0 = X, 1 = Y.
- z_ready  input  1  consumer accepts when z_valid && z_ready.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, x_ready=0, y_ready=0, z_valid=0, z_data=0, z_src=0, burst_cnt=0, last_served=Y (so X wins the first tie). A reset mid-transfer discards the output register contents.
- Handshake rules: a requester holds valid and data stable until accepted. Consumer side follows the same rule. z_data and z_src are stable while z_valid && !z_ready.
- out_free = !z_valid || z_ready (combinational from z_ready).
- x_ready = (state==GRANT_X) && out_free.
- y_ready = (state==GRANT_Y) && out_free.
- sel = 1 iff state==GRANT_Y.
- Transfer: the edge after x_valid && x_ready loads z_data<=x_data, z_src<=0, z_valid<=1. Y is symmetric with z_src<=1.
- If the consumer drains with no new transfer: z_valid<=0.
- Simultaneous drain and load: the register is overwritten and z_valid stays 1.
- Latency: 1 cycle from acceptance to z_valid. From IDLE, 1 cycle from valid to ready (grant cycle).
- Throughput: 1 word/cycle while granted and the consumer is ready.
- States: IDLE, GRANT_X, GRANT_Y.
- IDLE transitions:
  - x_valid && (!y_valid || last_served==Y) -> GRANT_X.
  - else y_valid -> GRANT_Y.
  - else stay IDLE.
  - burst_cnt=0 on entry to any grant.
- GRANT_X:
  - cnt_next = min(burst_cnt + xfer_x, BURST_MAX). A transfer sets last_served=X.
  - If !x_valid: go to GRANT_Y when y_valid, else IDLE.
  - Else if cnt_next==BURST_MAX && y_valid: go to GRANT_Y (cnt reset to 0). X keeps valid high and waits.
  - Else stay; burst_cnt<=cnt_next.
  - At saturation with y_valid low, X keeps streaming and the count stays at BURST_MAX. When y_valid rises, the switch happens at the next edge.
- GRANT_Y is symmetric.
- Switching directly between grants adds no bubble cycle. Ready for the new grantee asserts in the cycle after the switch edge.
- Consumer stall (z_ready=0 with z_valid=1): both readies are 0, the state holds, and burst_cnt does not advance.

Test Plan:
- Reset: assert rst mid-stream with z_valid=1 -> all outputs 0 immediately; after release, state IDLE and X wins the first tie.
- Single X: x_valid=1, x_data=16'h0000, y idle, z_ready=1 -> x_ready=1 in cycle 2; z_valid=1, z_data=16'h0000, z_src=0 in cycle 3; sel=0 throughout.
- Single Y: y_data=16'hFF00 -> sel=1, z_data=16'hFF00, z_src=1. Back-to-back Y words stream 1/cycle.
- Contention, BURST_MAX=4: both valid continuously, x_data=16'h0001.., y_data=16'hFF00.. -> z_src sequence 0,0,0,0,1,1,1,1,0,… with no lost or duplicated words.
- Backpressure: z_ready=0 for 5 cycles with z_valid=1 -> z_data/z_src held and x_ready=y_ready=0. On z_ready=1, simultaneous drain and load keeps z_valid=1.
- Early release: X sends 2 words then drops x_valid while y_valid=1 -> switch to GRANT_Y at the next edge. Y is not charged X's burst count; Y gets a full BURST_MAX.
